// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: fetch PC-source select, FSM states
// and the sizing helper for the sequence down-counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_POP    = 2'd2,
    PC_INT    = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_RET  = 2'd2,
    ST_INT  = 2'd3
  } hz_state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side event inputs and stall/flush/redirect outputs of the hazard
// controller; slave is the controller, master is the pipeline.
interface hazard_ctrl_unit_if #(
  parameter int REG_W = 3
);
  import hazard_pkg::*;

  logic             i_branch_taken;
  logic             i_push_pc;
  logic             i_pop_pc;
  logic             i_em_mem_read;
  logic [REG_W-1:0] i_em_rd;
  logic [REG_W-1:0] i_d_rs1;
  logic [REG_W-1:0] i_d_rs2;
  logic             i_d_rs1_used;
  logic             i_d_rs2_used;
  logic             i_int_req;
  logic             o_stall_f_d;
  logic             o_stall_d_em;
  logic             o_flush_f_d;
  logic             o_flush_d_em;
  pc_sel_e          o_pc_sel;
  logic             o_int_ack;
  logic             o_busy;

  modport master (
    output i_branch_taken, i_push_pc, i_pop_pc, i_em_mem_read, i_em_rd,
           i_d_rs1, i_d_rs2, i_d_rs1_used, i_d_rs2_used, i_int_req,
    input  o_stall_f_d, o_stall_d_em, o_flush_f_d, o_flush_d_em,
           o_pc_sel, o_int_ack, o_busy
  );

  modport slave (
    input  i_branch_taken, i_push_pc, i_pop_pc, i_em_mem_read, i_em_rd,
           i_d_rs1, i_d_rs2, i_d_rs1_used, i_d_rs2_used, i_int_req,
    output o_stall_f_d, o_stall_d_em, o_flush_f_d, o_flush_d_em,
           o_pc_sel, o_int_ack, o_busy
  );

endinterface

// File: rtl/hazard_seq_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement.
module hazard_seq_counter #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the F/D/EM core: multi-cycle CALL/RET, branch redirect,
// load-use bubbles; interrupt entry only when HAZARD_CTRL_INT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W       = 3,
  parameter int CALL_CYCLES = 2,
  parameter int RET_CYCLES  = 2,
  parameter int INT_CYCLES  = 3
) (
  input logic                i_clk,
  input logic                i_rst_n,
  hazard_ctrl_unit_if.slave  hz
);

  localparam int CNT_W = cnt_width(CALL_CYCLES, RET_CYCLES, INT_CYCLES);
  // A sequence of N cycles spends its first cycle in IDLE, so load N-2.
  localparam logic [CNT_W-1:0] CALL_LD = CNT_W'((CALL_CYCLES > 1) ? CALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] RET_LD  = CNT_W'((RET_CYCLES > 1) ? RET_CYCLES - 2 : 0);
`ifdef HAZARD_CTRL_INT_EN
  localparam logic [CNT_W-1:0] INT_LD  = CNT_W'((INT_CYCLES > 1) ? INT_CYCLES - 2 : 0);
`else
  logic unused_int_req;
  assign unused_int_req = hz.i_int_req;
`endif

  hz_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;
  logic             load_use;
  logic             stall_f_d, stall_d_em, flush_f_d, flush_d_em, int_ack;
  pc_sel_e          pc_sel;

  assign load_use = hz.i_em_mem_read &&
                    ((hz.i_d_rs1_used && (hz.i_em_rd == hz.i_d_rs1)) ||
                     (hz.i_d_rs2_used && (hz.i_em_rd == hz.i_d_rs2)));

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    stall_f_d  = 1'b0;
    stall_d_em = 1'b0;
    flush_f_d  = 1'b0;
    flush_d_em = 1'b0;
    pc_sel     = PC_SEQ;
    int_ack    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hz.i_push_pc) begin
          if (CALL_CYCLES == 1) begin
            if (hz.i_branch_taken) begin
              flush_f_d  = 1'b1;
              flush_d_em = 1'b1;
              pc_sel     = PC_BRANCH;
            end
          end else begin
            cnt_load   = 1'b1;
            cnt_ld_val = CALL_LD;
            state_d    = ST_CALL;
            stall_f_d  = 1'b1;
            stall_d_em = 1'b1;
          end
        end else if (hz.i_pop_pc) begin
          if (RET_CYCLES == 1) begin
            flush_f_d  = 1'b1;
            flush_d_em = 1'b1;
            pc_sel     = PC_POP;
          end else begin
            cnt_load   = 1'b1;
            cnt_ld_val = RET_LD;
            state_d    = ST_RET;
            stall_f_d  = 1'b1;
            stall_d_em = 1'b1;
          end
        end else if (hz.i_branch_taken) begin
          flush_f_d  = 1'b1;
          flush_d_em = 1'b1;
          pc_sel     = PC_BRANCH;
        end else if (load_use) begin
          stall_f_d  = 1'b1;
          flush_d_em = 1'b1;
        end
`ifdef HAZARD_CTRL_INT_EN
        else if (hz.i_int_req) begin
          if (INT_CYCLES == 1) begin
            flush_f_d  = 1'b1;
            flush_d_em = 1'b1;
            pc_sel     = PC_INT;
            int_ack    = 1'b1;
          end else begin
            cnt_load   = 1'b1;
            cnt_ld_val = INT_LD;
            state_d    = ST_INT;
            stall_f_d  = 1'b1;
            stall_d_em = 1'b1;
          end
        end
`endif
      end
      ST_CALL: begin
        if (!cnt_zero) begin
          stall_f_d  = 1'b1;
          stall_d_em = 1'b1;
          cnt_dec    = 1'b1;
        end else begin
          state_d = ST_IDLE;
          if (hz.i_branch_taken) begin
            flush_f_d  = 1'b1;
            flush_d_em = 1'b1;
            pc_sel     = PC_BRANCH;
          end
        end
      end
      ST_RET: begin
        if (!cnt_zero) begin
          stall_f_d  = 1'b1;
          stall_d_em = 1'b1;
          cnt_dec    = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          flush_f_d  = 1'b1;
          flush_d_em = 1'b1;
          pc_sel     = PC_POP;
        end
      end
`ifdef HAZARD_CTRL_INT_EN
      ST_INT: begin
        if (!cnt_zero) begin
          stall_f_d  = 1'b1;
          stall_d_em = 1'b1;
          cnt_dec    = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          flush_f_d  = 1'b1;
          flush_d_em = 1'b1;
          pc_sel     = PC_INT;
          int_ack    = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Reset aborts any sequence: both registers are cleared and nothing redirects.
    if (!i_rst_n) begin
      state_d    = ST_IDLE;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      stall_f_d  = 1'b0;
      stall_d_em = 1'b0;
      flush_f_d  = 1'b1;
      flush_d_em = 1'b1;
      pc_sel     = PC_SEQ;
      int_ack    = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  hazard_seq_counter #(.WIDTH(CNT_W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_ld_val),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  assign hz.o_stall_f_d  = stall_f_d;
  assign hz.o_stall_d_em = stall_d_em;
  assign hz.o_flush_f_d  = flush_f_d;
  assign hz.o_flush_d_em = flush_d_em;
  assign hz.o_pc_sel     = pc_sel;
  assign hz.o_int_ack    = int_ack;
  assign hz.o_busy       = busy_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: DUT a uses default cycle counts, DUT b uses CALL=3/RET=4/INT=1;
// both see the same inputs. Output word is {stall_fd,stall_dem,flush_fd,flush_dem,pc_sel[1:0],int_ack,busy}.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  hazard_ctrl_unit_if #(.REG_W(3)) ifa ();
  hazard_ctrl_unit_if #(.REG_W(3)) ifb ();

  hazard_ctrl_unit #(.REG_W(3), .CALL_CYCLES(2), .RET_CYCLES(2), .INT_CYCLES(3)) dut_a (
    .i_clk   (i_clk),
    .i_rst_n (rst_n),
    .hz      (ifa)
  );

  hazard_ctrl_unit #(.REG_W(3), .CALL_CYCLES(3), .RET_CYCLES(4), .INT_CYCLES(1)) dut_b (
    .i_clk   (i_clk),
    .i_rst_n (rst_n),
    .hz      (ifb)
  );

  logic [7:0] outs_a, outs_b;
  assign outs_a = {ifa.o_stall_f_d, ifa.o_stall_d_em, ifa.o_flush_f_d, ifa.o_flush_d_em,
                   ifa.o_pc_sel, ifa.o_int_ack, ifa.o_busy};
  assign outs_b = {ifb.o_stall_f_d, ifb.o_stall_d_em, ifb.o_flush_f_d, ifb.o_flush_d_em,
                   ifb.o_pc_sel, ifb.o_int_ack, ifb.o_busy};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic push, input logic pop, input logic br,
                        input logic mr, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic u1, input logic u2,
                        input logic irq);
    ifa.i_push_pc = push; ifa.i_pop_pc = pop; ifa.i_branch_taken = br;
    ifa.i_em_mem_read = mr; ifa.i_em_rd = rd; ifa.i_d_rs1 = rs1; ifa.i_d_rs2 = rs2;
    ifa.i_d_rs1_used = u1; ifa.i_d_rs2_used = u2; ifa.i_int_req = irq;
    ifb.i_push_pc = push; ifb.i_pop_pc = pop; ifb.i_branch_taken = br;
    ifb.i_em_mem_read = mr; ifb.i_em_rd = rd; ifb.i_d_rs1 = rs1; ifb.i_d_rs2 = rs2;
    ifb.i_d_rs1_used = u1; ifb.i_d_rs2_used = u2; ifb.i_int_req = irq;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0);
  endtask

  // Check both DUTs mid-cycle, then advance past the next rising edge.
  task automatic step(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    @(negedge i_clk);
    chk({tag, "_a"}, outs_a, ea);
    chk({tag, "_b"}, outs_b, eb);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    step("reset", 8'b0011_0000, 8'b0011_0000);
    rst_n = 1'b1;
    step("idle", 8'b0000_0000, 8'b0000_0000);

    // CALL with taken branch
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("call_br_c0", 8'b1100_0000, 8'b1100_0000);
    step("call_br_c1", 8'b0011_0101, 8'b1100_0001);
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("call_br_c2", 8'b0011_0100, 8'b0011_0101);
    idle_in();
    step("call_br_c3", 8'b0000_0000, 8'b0000_0000);

    // CALL without branch: final cycle is silent
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("call_nb_c0", 8'b1100_0000, 8'b1100_0000);
    step("call_nb_c1", 8'b0000_0001, 8'b1100_0001);
    idle_in();
    step("call_nb_c2", 8'b0000_0000, 8'b0000_0001);
    step("call_nb_c3", 8'b0000_0000, 8'b0000_0000);

    // RET
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("ret_c0", 8'b1100_0000, 8'b1100_0000);
    step("ret_c1", 8'b0011_1001, 8'b1100_0001);
    idle_in();
    step("ret_c2", 8'b0000_0000, 8'b1100_0001);
    step("ret_c3", 8'b0000_0000, 8'b0011_1001);
    step("ret_c4", 8'b0000_0000, 8'b0000_0000);

    // push and pop together: CALL wins
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("pushpop_c0", 8'b1100_0000, 8'b1100_0000);
    step("pushpop_c1", 8'b0000_0001, 8'b1100_0001);
    idle_in();
    step("pushpop_c2", 8'b0000_0000, 8'b0000_0001);
    step("pushpop_c3", 8'b0000_0000, 8'b0000_0000);

    // Load-use
    set_in(0, 0, 0, 1, 3'd5, 3'd0, 3'd5, 1, 1, 0);
    step("lu_rs2", 8'b1001_0000, 8'b1001_0000);
    set_in(0, 0, 0, 1, 3'd5, 3'd0, 3'd5, 1, 0, 0);
    step("lu_rs2_unused", 8'b0000_0000, 8'b0000_0000);
    set_in(0, 0, 0, 1, 3'd5, 3'd5, 3'd0, 1, 0, 0);
    step("lu_rs1", 8'b1001_0000, 8'b1001_0000);
    set_in(0, 0, 0, 1, 3'd4, 3'd5, 3'd5, 1, 1, 0);
    step("lu_rd_diff", 8'b0000_0000, 8'b0000_0000);
    set_in(0, 0, 0, 0, 3'd5, 3'd5, 3'd5, 1, 1, 0);
    step("lu_no_load", 8'b0000_0000, 8'b0000_0000);

    // Branch beats load-use
    set_in(0, 0, 1, 1, 3'd5, 3'd0, 3'd5, 0, 1, 0);
    step("br_lu", 8'b0011_0100, 8'b0011_0100);

    // Load-use beats interrupt
    set_in(0, 0, 0, 1, 3'd5, 3'd0, 3'd5, 0, 1, 1);
    step("lu_int", 8'b1001_0000, 8'b1001_0000);

    // Interrupt entry
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_CTRL_INT_EN
    step("int_c0", 8'b1100_0000, 8'b0011_1110);
    step("int_c1", 8'b1100_0001, 8'b0011_1110);
    step("int_c2", 8'b0011_1111, 8'b0011_1110);
`else
    step("int_c0", 8'b0000_0000, 8'b0000_0000);
    step("int_c1", 8'b0000_0000, 8'b0000_0000);
    step("int_c2", 8'b0000_0000, 8'b0000_0000);
`endif
    idle_in();
    step("int_c3", 8'b0000_0000, 8'b0000_0000);

    // Reset during a CALL stall cycle aborts the sequence
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("rstmid_c0", 8'b1100_0000, 8'b1100_0000);
    rst_n = 1'b0;
    @(negedge i_clk);
    chk("rstmid_c1_a", {1'b0, outs_a[7:1]}, 8'b0001_1000);
    chk("rstmid_c1_b", {1'b0, outs_b[7:1]}, 8'b0001_1000);
    @(posedge i_clk);
    #1;
    rst_n = 1'b1;
    idle_in();
    step("rstmid_c2", 8'b0000_0000, 8'b0000_0000);
    step("rstmid_c3", 8'b0000_0000, 8'b0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 3-stage (F, D, EM) RISC core; next generation of the single-state call/ret hazard unit. Sequences multi-cycle CALL/RET stack transfers of configurable length, redirects on taken branches, inserts load-use bubbles and, optionally, sequences interrupt entry. Sits beside the F/D and D/EM pipeline registers and drives their stall/flush controls and the fetch PC-source mux.

## Interface
- REG_W, 3: register-index width
- CALL_CYCLES, 2: EM cycles a CALL occupies (≥1)
- RET_CYCLES, 2: EM cycles a RET occupies (≥1)
- INT_CYCLES, 3: EM cycles an interrupt entry occupies (≥1)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_branch_taken  in  1  EM branch resolved taken
- i_push_pc  in  1  EM instruction is CALL
- i_pop_pc  in  1  EM instruction is RET
- i_em_mem_read  in  1  EM instruction is a load
- i_em_rd  in  REG_W  EM destination register
- i_d_rs1, i_d_rs2  in  REG_W  D source registers
- i_d_rs1_used, i_d_rs2_used  in  1  source actually read
- i_int_req  in  1  level interrupt request
- o_stall_f_d  out  1  hold PC and F/D register
- o_stall_d_em  out  1  hold D/EM register
- o_flush_f_d  out  1  clear F/D register
- o_flush_d_em  out  1  clear D/EM register (bubble)
- o_pc_sel  out  2  0 SEQ, 1 BRANCH, 2 POP, 3 INT_VEC
- o_int_ack  out  1  one-cycle interrupt-taken pulse
- o_busy  out  1  FSM not IDLE (registered)

## Operation
- FSM states IDLE, CALL, RET, INT; down-counter cnt, width $clog2(max cycles)+1.
- IDLE priority: i_push_pc > i_pop_pc > i_branch_taken > load-use > interrupt.
- CALL entry (IDLE, i_push_pc): if CALL_CYCLES=1, behaves as final cycle immediately; else cnt←CALL_CYCLES-2, state←CALL, outputs stall_f_d=stall_d_em=1.
- In CALL/RET/INT with cnt>0: stall both, cnt decrements.
- Final cycle (cnt=0, or 1-cycle op in IDLE): no stall; flush_f_d=flush_d_em=1; o_pc_sel = BRANCH (CALL, when i_branch_taken), POP (RET), INT_VEC (INT, plus o_int_ack=1); state←IDLE.
- CALL final cycle with i_branch_taken=0: no flush, o_pc_sel=SEQ.
- Branch in IDLE without push/pop: flush both, o_pc_sel=BRANCH, no state change.
- Load-use in IDLE: i_em_mem_read and i_em_rd equals a used D source → stall_f_d=1, flush_d_em=1, o_pc_sel=SEQ.
- Inputs ignored while not IDLE except i_branch_taken on CALL final cycle; EM is held, so inputs are stable.
- push and pop together: push wins.

## Timing
- Stall/flush/pc_sel/int_ack combinational from state and inputs; state, cnt, o_busy registered.
- CALL/RET/INT hold EM for exactly N cycles: N-1 stall cycles then one redirect cycle.
- While i_rst_n=0: flush_f_d=flush_d_em=1, all other outputs 0; on the clock edge state←IDLE, cnt←0, o_busy←0.
- Reset asserted mid-sequence aborts it; no redirect or int_ack issued.
- After a final cycle, IDLE accepts a new event on the next cycle.

## Configuration
- HAZARD_CTRL_INT_EN defined: INT state, interrupt acceptance in IDLE (lowest priority, only with no other event), o_int_ack driven.
- Undefined: i_int_req ignored, INT state absent, o_int_ack tied 0, o_pc_sel never 3; ports remain.

## Structure
- Shared package hazard_pkg: pc_sel enum (PC_SEQ, PC_BRANCH, PC_POP, PC_INT), FSM state enum.
- Sub-module hazard_seq_counter: loadable down-counter with load, decrement, zero flag, width parameter.

## Test plan
- Defaults, push_pc one cycle in IDLE, branch_taken=1 → cycle0 stall both; cycle1 flush both, pc_sel=1; o_busy 1 for one cycle.
- RET_CYCLES=4, pop_pc → 3 stall cycles, 4th cycle flush both, pc_sel=2, then IDLE.
- em_mem_read=1, em_rd=5, d_rs2=5, rs2_used=1 → stall_f_d=1, flush_d_em=1; with rs2_used=0 → all 0.
- branch_taken and load-use together → flush both, pc_sel=1, no stall.
- INT_EN, int_req=1 in IDLE with INT_CYCLES=3 → 2 stall cycles, then pc_sel=3, int_ack pulse; without INT_EN → no response.
- i_rst_n low during CALL stall cycle 1 (CALL_CYCLES=3) → flush outputs 1, next cycle o_busy=0, no pc_sel redirect.
